// File: rtl/serial_tx_framer.sv
// ---------------------------------------------------------------------------
// serial_tx_framer
//
// Byte-to-serial framer feeding a UART-style receiver: start bit 0, eight data
// bits LSB first, optional odd parity bit, STOP_BITS stop bits at 1, idle 1.
// Bytes arrive over a valid/ready handshake into a small FIFO. Frames are sent
// back-to-back, with no idle gap, for as long as bytes are queued.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   -> one odd-parity bit (~^data) between D7 and the first stop bit
//   undefined -> frame is start + 8 data + STOP_BITS stop bits
//
// Parameters:
//   FIFO_DEPTH  byte FIFO entries, power of two, 2..16
//   STOP_BITS   stop bits per frame, 1 or 2
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset; drops queued and in-flight bytes
//   in_byte     byte to transmit
//   in_valid    in_byte is valid
//   in_ready    FIFO can accept (combinational, fifo_count != FIFO_DEPTH)
//   out         registered serial line, idle high
//   busy        registered, high while a frame is being driven
//   fifo_count  bytes queued, excluding the byte in flight
// ---------------------------------------------------------------------------
module serial_tx_framer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;

  // Odd parity: the data bits plus this bit always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Frame engine state
  logic [2:0]    state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_idx_r;
  logic [1:0]    stop_cnt_r;
  logic          out_r;
  logic          busy_r;
`ifdef SERIAL_TX_PARITY_EN
  logic [7:0]    data_r;
`endif

  // Next-state values
  logic [2:0]    state_s;
  logic [7:0]    shift_s;
  logic [2:0]    bit_idx_s;
  logic [1:0]    stop_cnt_s;
  logic          out_s;

  // Handshake / pop decisions
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          last_stop_s;
  logic          nonempty_s;
  logic [7:0]    head_s;

  // FIFO status, handshake and pop decisions for the current cycle
  always_comb begin
    in_ready_s  = (count_r != CNT_FULL);
    nonempty_s  = (count_r != CNT_ZERO);
    push_s      = in_valid & in_ready_s;
    last_stop_s = (state_r == ST_STOP) && (stop_cnt_r == STOP_LAST);
    head_s      = mem_r[rd_ptr_r];
    // A byte is popped either from idle or on the final stop cycle, which is
    // what makes consecutive frames abut without an idle bit.
    if (nonempty_s && ((state_r == ST_IDLE) || last_stop_s)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Frame sequencing: next state, next line level and shift register
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_cnt_s = stop_cnt_r;
    out_s      = out_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_s = ST_START;
          shift_s = head_s;
          out_s   = 1'b0;
        end else begin
          out_s   = 1'b1;
        end
      end
      ST_START: begin
        state_s   = ST_DATA;
        out_s     = shift_r[0];
        shift_s   = {1'b0, shift_r[7:1]};
        bit_idx_s = 3'd0;
      end
      ST_DATA: begin
        // bit_idx_r counts data cycles already on the line; the line holds
        // D7 while bit_idx_r == 7.
        if (bit_idx_r == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
          state_s    = ST_PARITY;
          out_s      = odd_parity(data_r);
`else
          state_s    = ST_STOP;
          out_s      = 1'b1;
          stop_cnt_s = 2'd0;
`endif
        end else begin
          out_s     = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        state_s    = ST_STOP;
        out_s      = 1'b1;
        stop_cnt_s = 2'd0;
      end
`endif
      ST_STOP: begin
        if (last_stop_s) begin
          if (pop_s) begin
            state_s = ST_START;
            shift_s = head_s;
            out_s   = 1'b0;
          end else begin
            state_s = ST_IDLE;
            out_s   = 1'b1;
          end
        end else begin
          out_s      = 1'b1;
          stop_cnt_s = stop_cnt_r + 2'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        out_s   = 1'b1;
      end
    endcase
  end

  // Frame engine registers; reset drops the frame and parks the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 2'd0;
      out_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_cnt_r <= stop_cnt_s;
      out_r      <= out_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Full copy of the byte in flight, needed for parity after shifting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 8'h00;
    end else if (pop_s) begin
      data_r <= head_s;
    end else begin
      data_r <= data_r;
    end
  end
`endif

  // FIFO storage write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_byte;
    end
  end

  // FIFO pointers; power-of-two depth makes wrap a natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign out        = out_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_serial_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_framer
//
// Scoreboard bench for serial_tx_framer. Stimulus pushes each accepted byte's
// expected frame bits (and the byte itself) into queues; a monitor samples the
// line on every falling edge, pops and compares bits while busy, and runs a
// small serial receiver that rebuilds bytes and compares them in order.
// ---------------------------------------------------------------------------
module tb_serial_tx_framer;

  localparam int FIFO_DEPTH = 4;
  localparam int STOP_BITS  = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
  localparam logic [15:0] A5_FRAME = 16'h074A; // 0,1,0,1,0,0,1,0,1,P=1,1
`else
  localparam int PAR = 0;
  localparam logic [15:0] A5_FRAME = 16'h034A; // 0,1,0,1,0,0,1,0,1,1
`endif
  localparam int FL = 9 + STOP_BITS + PAR;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       busy;
  logic [2:0] fifo_count;

  serial_tx_framer #(.FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(STOP_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        b;
    logic [31:0] pc;   // clock edge at which the byte was accepted
  } exp_bit_t;

  exp_bit_t   exp_bits[$];
  logic [7:0] exp_bytes[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         rx_done  = 0;

  logic [7:0] ff_bytes [6] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h00};
  int         ff_cnt   [11] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4};
  logic [7:0] lb       [32];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
  endfunction

  function automatic void expect_frame(input logic [7:0] b, input int pc);
    exp_bit_t e;
    e.pc = 32'(pc);
    e.b  = 1'b0;
    exp_bits.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.b = b[i];
      exp_bits.push_back(e);
    end
`ifdef SERIAL_TX_PARITY_EN
    e.b = ~^b;
    exp_bits.push_back(e);
`endif
    for (int i = 0; i < STOP_BITS; i++) begin
      e.b = 1'b1;
      exp_bits.push_back(e);
    end
    exp_bytes.push_back(b);
  endfunction

  // One-cycle push; called at posedge+2, returns at the next posedge+2.
  task automatic push_byte(input logic [7:0] b);
    logic acc;
    int   edge_no;
    in_byte  = b;
    in_valid = 1'b1;
    acc      = in_ready;
    edge_no  = cyc + 1;
    @(posedge clk);
    if (acc) expect_frame(b, edge_no);
    #2;
    in_valid = 1'b0;
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((busy || exp_bits.size() != 0 || fifo_count != 3'd0) && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  // Monitor: bit scoreboard plus serial receiver model
  initial begin
    logic       prev_busy;
    int         rx_st;
    int         rx_n;
    logic [7:0] rx_sh;
    exp_bit_t   e;
    prev_busy = 1'b0;
    rx_st     = 0;
    rx_n      = 0;
    rx_sh     = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        rx_st     = 0;
      end else begin
        if (busy) begin
          if (exp_bits.size() == 0) begin
            chk("busy_without_data", 32'(busy), 32'd0);
          end else begin
            e = exp_bits.pop_front();
            chk("line_bit", 32'(out), 32'(e.b));
          end
        end else begin
          chk("idle_line_high", 32'(out), 32'd1);
          if (prev_busy && exp_bits.size() != 0)
            chk("back_to_back", 32'(busy), 32'(exp_bits[0].pc < 32'(cyc)));
        end
        prev_busy = busy;
        case (rx_st)
          0: begin
            if (out == 1'b0) begin
              rx_st = 1;
              rx_n  = 0;
            end
          end
          1: begin
            rx_sh[rx_n] = out;
            rx_n++;
            if (rx_n == 8) begin
              rx_n = 0;
`ifdef SERIAL_TX_PARITY_EN
              rx_st = 2;
`else
              rx_st = 3;
`endif
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          2: begin
            chk("rx_parity", 32'(out), 32'(~^rx_sh));
            rx_st = 3;
          end
`endif
          3: begin
            chk("rx_stop", 32'(out), 32'd1);
            rx_n++;
            if (rx_n == STOP_BITS) begin
              rx_done++;
              if (exp_bytes.size() == 0) chk("rx_byte_expected", 32'(exp_bytes.size()), 32'd1);
              else chk("rx_byte", 32'(rx_sh), 32'(exp_bytes.pop_front()));
              rx_st = 0;
            end
          end
          default: rx_st = 0;
        endcase
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [15:0] cap;
    logic        acc;
    int          e;
    int          idx;
    int          n;
    int          base;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out", 32'(out), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;

    // Idle after reset release
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      chk("idle_out", 32'(out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_count", 32'(fifo_count), 32'd0);
    end

    // Single 0xA5 frame, captured from the edge after acceptance
    push_byte(8'hA5);
    chk("a5_count_after_push", 32'(fifo_count), 32'd1);
    chk("a5_busy_after_push", 32'(busy), 32'd0);
    cap = 16'h0000;
    for (int i = 0; i < FL; i++) begin
      @(posedge clk);
      #2;
      cap[i] = out;
      chk("a5_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #2;
    chk("a5_busy_fall", 32'(busy), 32'd0);
    chk("a5_line_idle", 32'(out), 32'd1);
    chk("a5_frame", 32'(cap), 32'(A5_FRAME));
    wait_drain(5);

    // 0x00 then 0xFF on consecutive edges: two abutting frames
    push_byte(8'h00);
    push_byte(8'hFF);
    for (int i = 0; i < 2 * FL - 1; i++) begin
      @(posedge clk);
      #2;
      chk("pair_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #2;
    chk("pair_busy_fall", 32'(busy), 32'd0);
    wait_drain(5);

    // Fill the FIFO with in_valid held high from idle
    idx      = 0;
    in_valid = 1'b1;
    in_byte  = ff_bytes[0];
    for (int j = 0; j < 11; j++) begin
      acc = in_ready;
      e   = cyc + 1;
      @(posedge clk);
      if (acc) begin
        expect_frame(ff_bytes[idx], e);
        idx++;
      end
      #2;
      in_byte = ff_bytes[idx];
      chk("ff_count", 32'(fifo_count), 32'(ff_cnt[j]));
      chk("ff_ready", 32'(in_ready), 32'(ff_cnt[j] != 4));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("ff_count_after_pop", 32'(fifo_count), 32'd3);
    chk("ff_ready_after_pop", 32'(in_ready), 32'd1);
    chk("ff_accepted", 32'(idx), 32'd5);
    wait_drain(6 * FL + 20);

    // Asynchronous reset at D3 with two bytes queued
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    exp_bits.delete();
    exp_bytes.delete();
    #1;
    chk("async_rst_out", 32'(out), 32'd1);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    base = rx_done;
    push_byte(8'h3C);
    wait_drain(FL + 10);
    chk("post_rst_frames", 32'(rx_done - base), 32'd1);

    // Loopback: 32 random bytes, back-to-back
    for (int i = 0; i < 32; i++) lb[i] = 8'($urandom_range(0, 255));
    base     = rx_done;
    idx      = 0;
    n        = 0;
    in_valid = 1'b1;
    in_byte  = lb[0];
    while (idx < 32 && n < 32 * FL + 100) begin
      acc = in_ready;
      e   = cyc + 1;
      @(posedge clk);
      if (acc) begin
        expect_frame(lb[idx], e);
        idx++;
      end
      #2;
      if (idx < 32) in_byte = lb[idx];
      n++;
    end
    in_valid = 1'b0;
    chk("lb_accepted", 32'(idx), 32'd32);
    wait_drain((FIFO_DEPTH + 4) * FL);
    chk("lb_done_count", 32'(rx_done - base), 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_framer.md
# serial_tx_framer

Byte-to-serial framer that sits directly upstream of the serial receiver FSM (start bit 0, 8 data bits LSB first, stop bit 1, idle high). It accepts bytes over a valid/ready handshake into a small FIFO. It emits one frame per byte on a single registered serial line, at one bit per clock. Frames go back-to-back with no idle gap while data is queued, so the receiver's DONE→B0 path is exercised.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16
- STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; clears FIFO and FSM
- in_byte  input  8  byte to transmit
- in_valid  input  1  in_byte is valid
- in_ready  output  1  FIFO can accept; = (fifo_count != FIFO_DEPTH), combinational
- out  output  1  serial line, registered; idle level 1
- busy  output  1  registered; 1 while a frame is being driven (state != IDLE)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, not counting the byte in flight

## Operation
- Push: on an edge with in_valid && in_ready, in_byte is written at the write pointer and fifo_count increments.
- States:
  - IDLE: out=1. If fifo_count>0, pop into shift register, out<=0, go to START.
  - START (1 cycle): go to DATA, bit index 0; out<=shift[0].
  - DATA (8 cycles): shift right each cycle, LSB first. After bit 7, go to STOP (or PARITY, see Configuration); out<=1.
  - STOP: lasts STOP_BITS cycles, out=1. On the last stop cycle:
    - if fifo_count>0: pop, out<=0, go to START (no idle cycle);
    - otherwise go to IDLE.
- Simultaneous push and pop on the same edge: fifo_count unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Push while full is impossible because in_ready=0. in_valid with in_ready=0 is ignored; in_byte needs no hold.
- Reset (async, any time including mid-frame):
  - out=1, busy=0, fifo_count=0, in_ready=1, state=IDLE, pointers=0;
  - the in-flight byte and queued bytes are discarded.
  - A truncated frame reaches the downstream receiver; that receiver's ERR recovery on idle-high is the required system behaviour.

## Timing
- Push accepted at edge k into an empty FIFO while IDLE:
  - start bit is on out from edge k+1;
  - D0..D7 from edges k+2..k+9;
  - stop from edge k+10.
- Frame length: 1+8+STOP_BITS cycles (+1 with parity). Continuous throughput: one byte per frame length.
- busy rises with the start bit. It falls at the edge where out stays 1 and state returns to IDLE.
- in_ready reacts in the same cycle fifo_count changes, with no extra latency.
- fifo_count reflects pushes and pops of the previous edge.

## Configuration
- SERIAL_TX_PARITY_EN defined:
  - PARITY state (1 cycle) between D7 and the first stop bit;
  - out = odd parity of the byte, i.e. ~^data, so total ones across data+parity is odd;
  - frame length +1.
- Not defined: no parity state; DATA goes directly to STOP; frame exactly 9+STOP_BITS cycles.

## Test plan
- Reset release, idle: out=1, busy=0, in_ready=1, fifo_count=0 held for 20 cycles with in_valid=0.
- Single push 0xA5 at edge k:
  - out from edge k+1 = 0,1,0,1,0,0,1,0,1,1, then 1 idle;
  - busy high for 10 cycles;
  - with SERIAL_TX_PARITY_EN, parity bit 1 is inserted before stop.
- Push 0x00 then 0xFF on consecutive edges:
  - 20 contiguous frame cycles: 0, 0×8, 1, 0, 1×8, 1;
  - no idle cycle between the frames; busy stays high throughout.
- FIFO_DEPTH=4, in_valid held high from idle:
  - 5 bytes accepted (first popped immediately), then in_ready=0 with fifo_count=4;
  - in_ready returns to 1 the cycle after the first frame's last stop edge pops byte 2.
- Reset asserted at D3 of a frame with 2 bytes queued:
  - out=1 and fifo_count=0 immediately, without waiting for a clock edge;
  - after release, a new push of 0x3C produces a correct frame.
- Loopback into the downstream serial receiver with 32 random bytes, back-to-back:
  - receiver done pulses 32 times;
  - each out_byte equals the pushed byte, in order.
